// File: rtl/jt900h_intctl_pkg.sv
// Shared constants for the jt900h interrupt controller: register offsets,
// level width, NMI level and reset values.
package jt900h_intctl_pkg;
    localparam int             LVL_W     = 3;
    localparam logic           CTRL_OFS  = 1'b0;
    localparam logic           MASK_OFS  = 1'b1;
    localparam int             NMI_LVL   = 7;
    localparam logic [7:1]     MASK_RST  = 7'h7f;
    localparam logic [2:0]     VBASE_DEF = 3'd1;
endpackage

// File: rtl/jt900h_intctl_timer.sv
// cen-gated 8-bit countdown for delayed interrupts; periodic reload exists
// only when JT900H_INTCTL_AUTORELOAD_EN is defined.
module jt900h_intctl_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       load,
    input  logic       stop,
    input  logic [7:0] load_cnt,
    input  logic       reload_in,
    output logic [7:0] cnt,
    output logic       armed,
    output logic       reload,
    output logic       expire
);
    logic [7:0] period;

    // A CTRL write in the same cycle takes priority over expiry.
    assign expire = cen && armed && (cnt == 8'd0) && !load && !stop;

`ifdef JT900H_INTCTL_AUTORELOAD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period <= 8'd0;
            reload <= 1'b0;
        end else if (cen) begin
            if (load) begin
                period <= load_cnt;
                reload <= reload_in;
            end else if (stop) begin
                reload <= 1'b0;
            end
        end
    end
`else
    assign period = 8'd0;
    assign reload = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 8'd0;
            armed <= 1'b0;
        end else if (cen) begin
            if (load) begin
                cnt   <= load_cnt;
                armed <= 1'b1;
            end else if (stop) begin
                cnt   <= 8'd0;
                armed <= 1'b0;
            end else if (armed) begin
                if (cnt != 8'd0)
                    cnt <= cnt - 8'd1;
                else if (reload)
                    cnt <= period;
                else
                    armed <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/jt900h_intctl.sv
// Interrupt controller for the jt900h CPU: CTRL/MASK registers, pending
// levels, priority encoding and ack. Optional JT900H_INTCTL_AUTORELOAD_EN.
module jt900h_intctl
    import jt900h_intctl_pkg::*;
#(
    parameter logic [14:0] BASE  = 15'h7ff8,
    parameter logic [2:0]  VBASE = VBASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [23:1] addr,
    input  logic [15:0] din,
    input  logic [1:0]  we,
    input  logic        rd,
    output logic [15:0] dout,
    output logic        irq,
    input  logic        irq_ack,
    output logic [LVL_W-1:0] int_lvl,
    output logic [7:0]  int_addr
);
    logic             cs, wr_ctrl, wr_mask, load, stop, expire;
    logic             armed, reload;
    logic [7:0]       cnt;
    logic [LVL_W-1:0] arm_lvl;
    logic [7:1]       pending, pend_nxt, mask, eff;

    assign cs      = addr[15:2] == BASE[14:1];
    assign wr_ctrl = cs && addr[1] == CTRL_OFS && we[0];
    assign wr_mask = cs && addr[1] == MASK_OFS && we[0];
    assign load    = wr_ctrl && din[2:0] != 3'd0;
    assign stop    = wr_ctrl && din[2:0] == 3'd0;

    jt900h_intctl_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .load      (load),
        .stop      (stop),
        .load_cnt  (din[15:8]),
        .reload_in (din[3]),
        .cnt       (cnt),
        .armed     (armed),
        .reload    (reload),
        .expire    (expire)
    );

    assign eff = pending & mask;
    assign irq = |eff;

    always_comb begin
        int_lvl = '0;
        for (int i = 1; i <= 7; i++)
            if (eff[i]) int_lvl = LVL_W'(i);
    end

    assign int_addr = {VBASE, int_lvl, 2'd0};

    // Ack clears first so a same-level expiry in that cycle is kept;
    // a clear write overrides both.
    always_comb begin
        pend_nxt = pending;
        for (int i = 1; i <= 7; i++) begin
            if (irq_ack && irq && int_lvl == LVL_W'(i)) pend_nxt[i] = 1'b0;
            if (expire && arm_lvl == LVL_W'(i))         pend_nxt[i] = 1'b1;
        end
        if (stop) pend_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= MASK_RST;
            arm_lvl <= '0;
        end else if (cen) begin
            pending <= pend_nxt;
            if (wr_mask) begin
                mask[6:1]     <= din[6:1];
                mask[NMI_LVL] <= 1'b1;
            end
            // A clear write returns the timer to idle, so CTRL reads back 0.
            if (load)
                arm_lvl <= din[2:0];
            else if (stop)
                arm_lvl <= '0;
        end
    end

    always_comb begin
        dout = 16'd0;
        if (cs && addr[1] == CTRL_OFS)
            dout = {cnt, armed, 3'd0, reload, arm_lvl};
        else if (cs && addr[1] == MASK_OFS)
            dout = {pending, 1'b0, mask, 1'b0};
    end
endmodule

// File: tb/tb_jt900h_intctl.sv
// Self-checking bench for jt900h_intctl: directed scenarios plus randomized
// traffic against an event-time reference model.
module tb_jt900h_intctl;
    logic        clk = 1'b0;
    logic        rst_n, cen, rd, irq_ack;
    logic [23:1] addr;
    logic [15:0] din;
    logic [1:0]  we;
    logic [15:0] dout;
    logic        irq;
    logic [2:0]  int_lvl;
    logic [7:0]  int_addr;

    int n_checks = 0;
    int n_fail   = 0;

    jt900h_intctl dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .din(din), .we(we),
        .rd(rd), .dout(dout), .irq(irq), .irq_ack(irq_ack), .int_lvl(int_lvl),
        .int_addr(int_addr)
    );

    always #5 clk = ~clk;

    // Reference model: expiry is tracked as an absolute cen-edge number.
    int       m_edge = 0, m_exp = 0, m_period = 0, m_lvl = 0;
    bit       m_armed = 0, m_reload = 0;
    bit [7:0] m_pend = 0, m_mask = 8'hfe;

    function automatic bit m_cs();
        return (addr[15:1] & 15'h7ffe) == 15'h7ff8;
    endfunction

    function automatic int m_prio();
        for (int i = 7; i >= 1; i--)
            if (m_pend[i] && m_mask[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] m_dout();
        int c;
        c = m_armed ? (m_exp - m_edge - 1) : 0;
        if (!m_cs()) return 16'd0;
        if (!addr[1]) return {8'(c), m_armed, 3'b0, m_reload, 3'(m_lvl)};
        return {m_pend[7:1], 1'b0, m_mask[7:1], 1'b0};
    endfunction

    task automatic model_edge();
        int lvl;
        int n;
        if (!rst_n) begin
            m_armed = 0; m_reload = 0; m_lvl = 0; m_pend = 0; m_mask = 8'hfe;
            return;
        end
        if (!cen) return;
        m_edge++;
        lvl = m_prio();
        if (irq_ack && lvl != 0) m_pend[lvl] = 0;
        if (m_cs() && !addr[1] && we[0]) begin
            n = int'(din[15:8]);
            if (din[2:0] != 3'd0) begin
                m_armed = 1; m_lvl = int'(din[2:0]); m_period = n; m_exp = m_edge + n + 1;
`ifdef JT900H_INTCTL_AUTORELOAD_EN
                m_reload = din[3];
`endif
            end else begin
                m_armed = 0; m_lvl = 0; m_reload = 0; m_pend = 0;
            end
        end else if (m_armed && m_edge == m_exp) begin
            m_pend[m_lvl] = 1;
            if (m_reload) m_exp = m_edge + m_period + 1;
            else          m_armed = 0;
        end
        if (m_cs() && addr[1] && we[0]) m_mask[6:1] = din[6:1];
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel_mask, input logic [15:0] d);
        addr = {8'($urandom), 14'h3ffc, sel_mask};
        din  = d;
        we   = ($urandom % 2) ? 2'b11 : 2'b01;
        step();
        we   = 2'b00;
        addr = 23'h0;
    endtask

    task automatic sel(input bit sel_mask);
        addr = {8'($urandom), 14'h3ffc, sel_mask};
        #1;
    endtask

    task automatic test_reset();
        cen = 1'b0; irq_ack = 1'b0; we = 2'b00; din = 16'h0; rd = 1'b0; addr = 23'h0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        n_checks++;
        if (irq !== 1'b0 || int_lvl !== 3'd0) begin
            n_fail++; $display("FAIL reset_irq: irq=%b lvl=%0d, want 0/0", irq, int_lvl);
        end
        n_checks++;
        if (int_addr !== 8'h20) begin
            n_fail++; $display("FAIL reset_int_addr: got %h want 20", int_addr);
        end
        sel(0);
        n_checks++;
        if (dout !== 16'h0000) begin
            n_fail++; $display("FAIL reset_ctrl_read: got %h want 0000", dout);
        end
        sel(1);
        n_checks++;
        if (dout !== 16'h00fe) begin
            n_fail++; $display("FAIL reset_mask_read: got %h want 00fe", dout);
        end
        addr = 23'h0;
        cen = 1'b1;
    endtask

    task automatic test_oneshot();
        bit early = 0;
        wr(0, 16'h0503);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (irq !== 1'b0) early = 1;
        end
        n_checks++;
        if (early) begin
            n_fail++; $display("FAIL oneshot_early: irq rose before edge 6, want 0");
        end
        step();
        n_checks++;
        if (irq !== 1'b1 || int_lvl !== 3'd3 || int_addr !== 8'h2c) begin
            n_fail++;
            $display("FAIL oneshot_fire: irq=%b lvl=%0d addr=%h, want 1/3/2c", irq, int_lvl, int_addr);
        end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_ack: irq=%b want 0", irq);
        end
    endtask

    task automatic test_priority();
        wr(0, 16'h0002); step();
        wr(0, 16'h0005); step();
        n_checks++;
        if (irq !== 1'b1 || int_lvl !== 3'd5) begin
            n_fail++; $display("FAIL prio_high: irq=%b lvl=%0d want 1/5", irq, int_lvl);
        end
        irq_ack = 1'b1; step();
        n_checks++;
        if (irq !== 1'b1 || int_lvl !== 3'd2 || int_addr !== 8'h28) begin
            n_fail++; $display("FAIL prio_next: irq=%b lvl=%0d addr=%h want 1/2/28", irq, int_lvl, int_addr);
        end
        step(); irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL prio_done: irq=%b want 0", irq);
        end
    endtask

    task automatic test_mask();
        wr(1, 16'h0000);
        wr(0, 16'h0004); step();
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL mask_block: irq=%b want 0", irq);
        end
        sel(1);
        n_checks++;
        if (dout !== 16'h1080) begin
            n_fail++; $display("FAIL mask_read: got %h want 1080", dout);
        end
        wr(0, 16'h0007); step();
        n_checks++;
        if (irq !== 1'b1 || int_lvl !== 3'd7 || int_addr !== 8'h3c) begin
            n_fail++; $display("FAIL mask_nmi: irq=%b lvl=%0d addr=%h want 1/7/3c", irq, int_lvl, int_addr);
        end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        wr(1, 16'h007e);
        n_checks++;
        if (irq !== 1'b1 || int_lvl !== 3'd4) begin
            n_fail++; $display("FAIL mask_unmask: irq=%b lvl=%0d want 1/4", irq, int_lvl);
        end
        wr(0, 16'h0000);
    endtask

    task automatic test_simul();
        wr(0, 16'h0003); step();
        wr(0, 16'h0103); step();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b1 || int_lvl !== 3'd3) begin
            n_fail++; $display("FAIL simul_set_wins: irq=%b lvl=%0d want 1/3", irq, int_lvl);
        end
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL simul_final_ack: irq=%b want 0", irq);
        end
    endtask

    task automatic test_rst_abort();
        bit seen = 0;
        wr(0, 16'h1004);
        for (int k = 0; k < 8; k++) step();
        sel(0);
        n_checks++;
        if (dout !== 16'h0884) begin
            n_fail++; $display("FAIL abort_cnt8: got %h want 0884", dout);
        end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (irq !== 1'b0) seen = 1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_irq: irq seen after reset, want none");
        end
        wr(0, 16'h0001); step();
        wr(0, 16'h0000);
        sel(0);
        n_checks++;
        if (irq !== 1'b0 || dout !== 16'h0000) begin
            n_fail++; $display("FAIL clear_write: irq=%b ctrl=%h want 0/0000", irq, dout);
        end
        addr = 23'h0;
    endtask

    task automatic test_reload();
        int  bad = 0;
        bit  exp_irq;
        wr(0, 16'h020b);
        sel(0);
        n_checks++;
`ifdef JT900H_INTCTL_AUTORELOAD_EN
        if (dout[3] !== 1'b1) begin
`else
        if (dout[3] !== 1'b0) begin
`endif
            n_fail++; $display("FAIL reload_bit: got %b", dout[3]);
        end
        addr = 23'h0;
        for (int k = 1; k <= 9; k++) begin
            irq_ack = (k % 3 == 1) && (k > 1);
            step();
`ifdef JT900H_INTCTL_AUTORELOAD_EN
            exp_irq = (k % 3 == 0);
`else
            exp_irq = (k == 3);
`endif
            if (irq !== exp_irq) bad++;
        end
        irq_ack = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL reload_period: %0d cycles with wrong irq, want 0", bad);
        end
        wr(0, 16'h0000);
    endtask

    task automatic test_random();
        int bad_out = 0, bad_rd = 0, lv;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom % 3)
                0: addr = {8'($urandom), 14'h3ffc, 1'b0};
                1: addr = {8'($urandom), 14'h3ffc, 1'b1};
                default: addr = 23'($urandom);
            endcase
            din     = {5'd0, 3'($urandom), 8'($urandom)};
            we      = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
            rd      = 1'($urandom);
            cen     = ($urandom % 8) != 0;
            rst_n   = ($urandom % 400) != 0;
            irq_ack = ($urandom % 3) == 0;
            #1;
            if (dout !== m_dout()) begin
                bad_rd++;
                if (bad_rd < 5) $display("FAIL rand_read: addr=%h dout=%h want %h", addr, dout, m_dout());
            end
            step();
            lv = m_prio();
            if (irq !== (lv != 0) || int_lvl !== 3'(lv) || int_addr !== {3'd1, 3'(lv), 2'b00}) begin
                bad_out++;
                if (bad_out < 5) $display("FAIL rand_irq: irq=%b lvl=%0d want lvl %0d", irq, int_lvl, lv);
            end
        end
        n_checks++;
        if (bad_rd != 0) begin
            n_fail++; $display("FAIL rand_read_total: %0d bad reads, want 0", bad_rd);
        end
        n_checks++;
        if (bad_out != 0) begin
            n_fail++; $display("FAIL rand_irq_total: %0d bad cycles, want 0", bad_out);
        end
        we = 2'b00; irq_ack = 1'b0; rst_n = 1'b1; cen = 1'b1;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_priority();
        test_mask();
        test_simul();
        test_rst_abort();
        test_reload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jt900h_intctl.md
Name: jt900h_intctl

Overview:
- Synthesizable interrupt controller acting as the bus responder and interrupt source for the jt900h CPU core.
- The CPU programs delayed interrupt events through two memory-mapped words.
- The block raises irq with a 3-bit level and a vector address, and retires the request on irq_ack.
- It replaces bench-only interrupt stimulus so interrupt behaviour can be exercised in synthesized systems.

Parameters:
- BASE, 15'h7ff8: word address compared against addr[15:1]; CTRL at BASE, MASK at BASE+1.
- VBASE, 3'd1: upper 3 bits of int_addr.

Ports:
- clk       in   1   system clock
- rst_n     in   1   reset, synchronous, active-low
- cen       in   1   clock enable; all state updates happen only on clk edges with cen=1
- addr      in   23  CPU word address [23:1]
- din       in   16  write data from CPU
- we        in   2   byte write enables: [1] high byte, [0] low byte
- rd        in   1   read strobe
- dout      out  16  read data, combinational from the registers
- irq       out  1   interrupt request
- irq_ack   in   1   CPU acknowledge; single-cycle pulse
- int_lvl   out  3   level of the request being presented
- int_addr  out  8   vector address, {VBASE, int_lvl, 2'd0}

Behaviour:
- Chip select: cs = addr[15:2]==BASE[14:1]; addr[1] selects CTRL (0) or MASK (1). Upper address bits are ignored (partial decode).
- Reset (rst_n=0 at a clk edge, cen ignored):
  - cnt=0, armed=0, arm_lvl=0, pending[7:1]=0, mask[7:1]=7'h7f
  - outputs: irq=0, int_lvl=0, int_addr={VBASE,5'd0}, dout=0
- CTRL write (cs, addr[1]=0, we[0]=1):
  - if din[2:0]!=0: cnt<=din[15:8], arm_lvl<=din[2:0], armed<=1. Re-arming while armed restarts the timer.
  - if din[2:0]==0: armed<=0, pending<=0.
  - we[1] alone: no effect.
- MASK write (cs, addr[1]=1, we[0]=1): mask[6:1]<=din[6:1]. Level 7 is non-maskable; mask[7] stays 1.
- Timer, on each cen edge when armed and no CTRL write:
  - cnt!=0: cnt<=cnt-1
  - cnt==0: pending[arm_lvl]<=1, armed<=0
  - Result: pending is set on the (N+1)th cen edge after the write edge. N=0 gives the next cen edge.
- Request logic (combinational from registers):
  - eff = pending & mask
  - irq = |eff
  - int_lvl = index of highest set bit of eff, 0 if none
  - A higher level becoming pending while irq is high updates int_lvl immediately.
- Acknowledge: irq_ack on a cen edge clears pending[int_lvl] as presented in that cycle. irq_ack with irq=0 is ignored.
- Simultaneous events: timer expiry setting the same level that is acked in that cycle → the set wins. A CTRL clear write in the ack cycle → all pending cleared.
- Reads, when cs=1, regardless of rd:
  - CTRL: dout = {cnt, armed, 4'd0, arm_lvl}
  - MASK: dout = {pending[7:1], 1'b0, mask[7:1], 1'b0}
  - otherwise dout=0
- rst_n low mid-countdown: timer aborts; no pending survives reset.

Optional Feature:
- Macro: JT900H_INTCTL_AUTORELOAD_EN.
- With the macro: CTRL din[3] is the reload bit. When reload=1, expiry reloads cnt from the latched count and armed stays 1, giving a periodic interrupt every N+1 cen edges. CTRL read bit [3] reports reload.
- Without the macro: one-shot only; din[3] is ignored and reads as 0.

Decomposition:
- Package jt900h_intctl_pkg holds:
  - CTRL/MASK word offsets
  - level width (3)
  - NMI level constant (7)
  - reset mask constant
  - vector-base default
- Sub-module jt900h_intctl_timer: 8-bit cen-gated down-counter with load, arm, expire pulse, and (optional) reload.
- Top-level holds decode, pending/mask, priority encoder, and ack.

Test Plan:
- Write CTRL 16'h0503, cen=1 → pending[3] set on the 6th edge after the write, irq=1, int_lvl=3, int_addr=8'h2C. Pulse irq_ack → irq=0 next cycle.
- Arm level 2, then level 5 after expiry with count 0 → int_lvl=5. Ack → int_lvl=2. Ack → irq=0.
- MASK write 16'h0000, arm level 4 → pending visible in MASK read, irq=0. Arm level 7 → irq=1, int_lvl=7 (NMI).
- Expiry on level 3 in the same cycle as ack of a presented level-3 request → pending[3] remains 1 and irq stays high.
- Write CTRL 16'h1004, assert rst_n=0 at countdown 8 → no irq ever. Write CTRL 16'h0000 with pending set → irq drops, CTRL read = 0.
- With JT900H_INTCTL_AUTORELOAD_EN: CTRL 16'h020B → a level-3 pending appears every 3 cen edges; acks between expiries each retire one event.
